// File: rtl/sat_search_ctrl_if.sv
// Handshake bundle between the SAT search sequencer and its decision, BCP and backtrack engines.
// The sequencer side uses the master modport; the engines (or a bench) use the slave modport.
interface sat_search_ctrl_if #(
    parameter int VAR_W = 3,
    parameter int LVL_W = 4
);
    logic             start;
    logic             decision_en;
    logic             decision_finish;
    logic [VAR_W-1:0] dec_var;
    logic             dec_value;
    logic             all_assigned;
    logic             bcp_en;
    logic             bcp_done;
    logic             bcp_conflict;
    logic             bt_en;
    logic [LVL_W-1:0] bt_level;
    logic [VAR_W-1:0] bt_var;
    logic             bt_value;
    logic             bt_done;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             sat;
    logic             unsat;
    logic             overflow;

    modport master (
        input  start, decision_finish, dec_var, dec_value, all_assigned,
               bcp_done, bcp_conflict, bt_done,
        output decision_en, bcp_en, bt_en, bt_level, bt_var, bt_value,
               level, busy, sat, unsat, overflow
    );

    modport slave (
        output start, decision_finish, dec_var, dec_value, all_assigned,
               bcp_done, bcp_conflict, bt_done,
        input  decision_en, bcp_en, bt_en, bt_level, bt_var, bt_value,
               level, busy, sat, unsat, overflow
    );
endinterface

// File: rtl/sat_search_ctrl.sv
// DPLL search sequencer with chronological backtracking: sequences decide / BCP / backtrack
// engines through 1-cycle pulse handshakes and keeps the decision trail stack.
module sat_search_ctrl #(
    parameter int VAR_NUM   = 8,
    parameter int VAR_W     = $clog2(VAR_NUM),
    parameter int MAX_LEVEL = 8,
    parameter int LVL_W     = $clog2(MAX_LEVEL) + 1
) (
    input  logic              clock,
    input  logic              reset,
    sat_search_ctrl_if.master bus
);
    localparam int IDX_W = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_BCP0, S_CHECK, S_DEC, S_PUSH, S_BCP, S_FIND, S_FLIP, S_SAT, S_UNSAT, S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic             first_reg;
    logic             seen_low_reg;
    logic [LVL_W-1:0] level_reg;
    logic [VAR_W-1:0] dec_var_reg;
    logic             dec_value_reg;
    logic [LVL_W-1:0] bt_level_reg;
    logic [VAR_W-1:0] bt_var_reg;
    logic             bt_value_reg;
    logic             busy_reg, sat_reg, unsat_reg, overflow_reg;

    logic [VAR_W-1:0] ent_var_reg   [MAX_LEVEL];
    logic             ent_value_reg [MAX_LEVEL];
    logic             ent_flip_reg  [MAX_LEVEL];

    logic             start_acc, push_we, pop_we, flip_go;
    logic             dec_done, level_zero, level_full, top_flip;
    logic [LVL_W-1:0] top_lvl;
    logic [IDX_W-1:0] top_idx, push_idx;

    assign top_lvl    = level_reg - LVL_W'(1);
    assign top_idx    = top_lvl[IDX_W-1:0];
    assign push_idx   = level_reg[IDX_W-1:0];
    assign top_flip   = ent_flip_reg[top_idx];
    assign level_zero = (level_reg == '0);
    assign level_full = (level_reg == LVL_W'(MAX_LEVEL));
    // A finish flag left high from the engine's idle period only counts once a low was observed.
    assign dec_done   = seen_low_reg & bus.decision_finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= (state_next != state_reg);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_BCP0;
            S_BCP0:  if (bus.bcp_done) state_next = bus.bcp_conflict ? S_UNSAT : S_CHECK;
            S_CHECK: begin
                if (bus.all_assigned)  state_next = S_SAT;
                else if (level_full)   state_next = S_ERR;
                else                   state_next = S_DEC;
            end
            S_DEC:   if (dec_done) state_next = S_PUSH;
            S_PUSH:  state_next = S_BCP;
            S_BCP:   if (bus.bcp_done) state_next = bus.bcp_conflict ? S_FIND : S_CHECK;
            S_FIND: begin
                if (level_zero)     state_next = S_UNSAT;
                else if (!top_flip) state_next = S_FLIP;
            end
            S_FLIP:  if (bus.bt_done) state_next = S_BCP;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.decision_en = (state_reg == S_DEC) && first_reg;
        bus.bcp_en      = ((state_reg == S_BCP0) || (state_reg == S_BCP)) && first_reg;
        bus.bt_en       = (state_reg == S_FLIP) && first_reg;
        start_acc       = (state_reg == S_IDLE) && bus.start;
        push_we         = (state_reg == S_PUSH);
        pop_we          = (state_reg == S_FIND) && !level_zero && top_flip;
        flip_go         = (state_reg == S_FIND) && !level_zero && !top_flip;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_reg     <= '0;
            seen_low_reg  <= 1'b0;
            dec_var_reg   <= '0;
            dec_value_reg <= 1'b0;
            bt_level_reg  <= '0;
            bt_var_reg    <= '0;
            bt_value_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            unsat_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (start_acc) begin
                level_reg    <= '0;
                busy_reg     <= 1'b1;
                sat_reg      <= 1'b0;
                unsat_reg    <= 1'b0;
                overflow_reg <= 1'b0;
            end
            if (push_we) level_reg <= level_reg + LVL_W'(1);
            if (pop_we)  level_reg <= top_lvl;
            if (state_reg != S_DEC)        seen_low_reg <= 1'b0;
            else if (!bus.decision_finish) seen_low_reg <= 1'b1;
            if (state_reg == S_DEC && dec_done) begin
                dec_var_reg   <= bus.dec_var;
                dec_value_reg <= bus.dec_value;
            end
            // Backtrack request is captured as FLIP is entered so it is stable during bt_en.
            if (flip_go) begin
                bt_level_reg <= level_reg;
                bt_var_reg   <= ent_var_reg[top_idx];
                bt_value_reg <= ~ent_value_reg[top_idx];
            end
            if (state_reg == S_SAT)   begin sat_reg      <= 1'b1; busy_reg <= 1'b0; end
            if (state_reg == S_UNSAT) begin unsat_reg    <= 1'b1; busy_reg <= 1'b0; end
            if (state_reg == S_ERR)   begin overflow_reg <= 1'b1; busy_reg <= 1'b0; end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEVEL; gi++) begin : g_stack
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ent_var_reg[gi]   <= '0;
                    ent_value_reg[gi] <= 1'b0;
                    ent_flip_reg[gi]  <= 1'b0;
                end else if (push_we && push_idx == IDX_W'(gi)) begin
                    ent_var_reg[gi]   <= dec_var_reg;
                    ent_value_reg[gi] <= dec_value_reg;
                    ent_flip_reg[gi]  <= 1'b0;
                end else if (flip_go && top_idx == IDX_W'(gi)) begin
                    // The flipped variable keeps its level; only its value and flag change.
                    ent_value_reg[gi] <= ~ent_value_reg[gi];
                    ent_flip_reg[gi]  <= 1'b1;
                end
            end
        end
    endgenerate

    assign bus.level    = level_reg;
    assign bus.bt_level = bt_level_reg;
    assign bus.bt_var   = bt_var_reg;
    assign bus.bt_value = bt_value_reg;
    assign bus.busy     = busy_reg;
    assign bus.sat      = sat_reg;
    assign bus.unsat    = unsat_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_sat_search_ctrl.sv
// Directed bench for sat_search_ctrl: the bench plays all three engines and scoreboards
// expected backtrack requests and final outcomes.
module tb_sat_search_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sat_search_ctrl_if #(.VAR_W(3), .LVL_W(4)) bus ();

    sat_search_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       sat;
        logic       unsat;
        logic       ovf;
        logic [3:0] level;
    } outcome_t;

    typedef struct {
        logic [3:0] lvl;
        logic [2:0] var_i;
        logic       val;
    } bt_t;

    outcome_t out_q[$];
    bt_t      bt_q[$];
    int       checks = 0;
    int       errors = 0;
    int       dec_cnt = 0;
    int       base;

    always @(negedge clock) if (bus.decision_en === 1'b1) dec_cnt <= dec_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return bus.bcp_en;
            1:       return bus.decision_en;
            2:       return bus.bt_en;
            default: return !bus.busy;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int maxc, input string tag);
        int n = 0;
        while (sig_sel(sel) !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        assert (sig_sel(sel) === 1'b1) else begin
            errors++;
            $error("FAIL %s: timeout after %0d cycles, observed 0 expected 1", tag, maxc);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // done is returned on the same cycle bcp_en is seen
    task automatic bcp_respond(input logic conflict, input string tag);
        wait_for(0, 20, tag);
        bus.bcp_done     = 1'b1;
        bus.bcp_conflict = conflict;
        tick();
        bus.bcp_done     = 1'b0;
        bus.bcp_conflict = 1'b0;
    endtask

    task automatic decide(input logic [2:0] v, input logic val, input string tag);
        wait_for(1, 20, tag);
        bus.decision_finish = 1'b0;
        tick();
        bus.dec_var         = v;
        bus.dec_value       = val;
        bus.decision_finish = 1'b1;
        tick();
    endtask

    task automatic bt_respond(input string tag);
        bt_t e;
        wait_for(2, 20, tag);
        if (bt_q.size() > 0) begin
            e = bt_q.pop_front();
            check({tag, "_level"}, 32'(bus.bt_level), 32'(e.lvl));
            check({tag, "_var"},   32'(bus.bt_var),   32'(e.var_i));
            check({tag, "_value"}, 32'(bus.bt_value), 32'(e.val));
        end
        bus.bt_done = 1'b1;
        tick();
        bus.bt_done = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        outcome_t e;
        wait_for(3, maxc, {tag, "_done"});
        if (out_q.size() > 0) begin
            e = out_q.pop_front();
            check({tag, "_sat"},      32'(bus.sat),      32'(e.sat));
            check({tag, "_unsat"},    32'(bus.unsat),    32'(e.unsat));
            check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
            check({tag, "_level"},    32'(bus.level),    32'(e.level));
        end
        $display("txn %s: sat=%0b unsat=%0b overflow=%0b level=%0d", tag,
                 bus.sat, bus.unsat, bus.overflow, bus.level);
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.decision_finish = 1'b1;
        bus.dec_var         = '0;
        bus.dec_value       = 1'b0;
        bus.all_assigned    = 1'b0;
        bus.bcp_done        = 1'b0;
        bus.bcp_conflict    = 1'b0;
        bus.bt_done         = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_busy",  32'(bus.busy),  0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_flags", 32'({bus.sat, bus.unsat, bus.overflow}), 0);
        check("rst_en",    32'({bus.bcp_en, bus.decision_en, bus.bt_en}), 0);

        // T1: conflict on the very first BCP
        base = dec_cnt;
        out_q.push_back('{sat: 1'b0, unsat: 1'b1, ovf: 1'b0, level: 4'd0});
        do_start();
        check("t1_bcp_en_latency", 32'(bus.bcp_en), 1);
        bcp_respond(1'b1, "t1_bcp0");
        wait_done(3, "t1");
        check("t1_no_decision", 32'(dec_cnt - base), 0);

        // T2: three clean decisions then all assigned
        base = dec_cnt;
        out_q.push_back('{sat: 1'b1, unsat: 1'b0, ovf: 1'b0, level: 4'd3});
        do_start();
        check("t2_busy", 32'(bus.busy), 1);
        check("t2_flags_cleared", 32'(bus.unsat), 0);
        bcp_respond(1'b0, "t2_bcp0");
        for (int i = 0; i < 3; i++) begin
            decide(3'(i), 1'b0, "t2_dec");
            bcp_respond(1'b0, "t2_bcp");
        end
        bus.all_assigned = 1'b1;
        wait_done(10, "t2");
        bus.all_assigned = 1'b0;
        check("t2_decisions", 32'(dec_cnt - base), 3);

        // T3: single decision flipped after a conflict
        do_start();
        bcp_respond(1'b0, "t3_bcp0");
        decide(3'd5, 1'b0, "t3_dec");
        bt_q.push_back('{lvl: 4'd1, var_i: 3'd5, val: 1'b1});
        bcp_respond(1'b1, "t3_bcp_conf");
        bt_respond("t3_bt");
        bcp_respond(1'b0, "t3_bcp_clean");
        check("t3_level_after_flip", 32'(bus.level), 1);
        out_q.push_back('{sat: 1'b1, unsat: 1'b0, ovf: 1'b0, level: 4'd1});
        bus.all_assigned = 1'b1;
        wait_done(10, "t3");
        bus.all_assigned = 1'b0;

        // T4: flip the deepest, pop, flip the next, exhaust to UNSAT
        do_start();
        bcp_respond(1'b0, "t4_bcp0");
        decide(3'd2, 1'b0, "t4_dec_a");
        bcp_respond(1'b0, "t4_bcp_a");
        decide(3'd3, 1'b0, "t4_dec_b");
        bt_q.push_back('{lvl: 4'd2, var_i: 3'd3, val: 1'b1});
        bcp_respond(1'b1, "t4_conf1");
        bt_respond("t4_bt1");
        bt_q.push_back('{lvl: 4'd1, var_i: 3'd2, val: 1'b1});
        bcp_respond(1'b1, "t4_conf2");
        bt_respond("t4_bt2");
        check("t4_level_after_pop", 32'(bus.level), 1);
        out_q.push_back('{sat: 1'b0, unsat: 1'b1, ovf: 1'b0, level: 4'd0});
        bcp_respond(1'b1, "t4_conf3");
        wait_done(10, "t4");

        // T5: trail overflow
        base = dec_cnt;
        out_q.push_back('{sat: 1'b0, unsat: 1'b0, ovf: 1'b1, level: 4'd8});
        do_start();
        bcp_respond(1'b0, "t5_bcp0");
        for (int i = 0; i < 8; i++) begin
            decide(3'(i), 1'(i & 1), "t5_dec");
            bcp_respond(1'b0, "t5_bcp");
        end
        wait_done(10, "t5");
        repeat (4) tick();
        check("t5_decisions", 32'(dec_cnt - base), 8);
        check("t5_busy", 32'(bus.busy), 0);

        // T6: reset mid-BCP, stray bcp_done, then a run with a stale-high finish flag
        do_start();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.bcp_done = 1'b1;
        tick();
        bus.bcp_done = 1'b0;
        repeat (2) tick();
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_level", 32'(bus.level), 0);
        check("t6_flags", 32'({bus.sat, bus.unsat, bus.overflow}), 0);
        check("t6_en", 32'({bus.bcp_en, bus.decision_en, bus.bt_en}), 0);

        out_q.push_back('{sat: 1'b1, unsat: 1'b0, ovf: 1'b0, level: 4'd1});
        do_start();
        bcp_respond(1'b0, "t6_bcp0");
        wait_for(1, 20, "t6_dec_en");
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("t6_no_push_level", 32'(bus.level), 0);
        check("t6_no_bcp", 32'(bus.bcp_en), 0);
        check("t6_still_busy", 32'(bus.busy), 1);
        bus.decision_finish = 1'b0;
        tick();
        bus.dec_var         = 3'd6;
        bus.dec_value       = 1'b1;
        bus.decision_finish = 1'b1;
        tick();
        bcp_respond(1'b0, "t6_bcp");
        check("t6_level_pushed", 32'(bus.level), 1);
        bus.all_assigned = 1'b1;
        wait_done(10, "t6");
        bus.all_assigned = 1'b0;

        check("scoreboard_empty", 32'(out_q.size() + bt_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
